// File: rtl/alu_issue_stage_if.sv
// Handshake and payload bundle between register read, the issue stage and the ALU.
interface alu_issue_stage_if #(
  parameter int unsigned OPERAND_LENGTH = 32
);
  // Upstream side: decoded beat plus operand sources
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               instr;
  logic [OPERAND_LENGTH-1:0] pc;
  logic [OPERAND_LENGTH-1:0] rs1_data;
  logic [OPERAND_LENGTH-1:0] rs2_data;

  // Downstream side: operand/select bundle for the ALU
  logic                      out_valid;
  logic                      out_ready;
  logic [OPERAND_LENGTH-1:0] opd1;
  logic [OPERAND_LENGTH-1:0] opd2;
  logic [OPERAND_LENGTH-1:0] opd3;
  logic [OPERAND_LENGTH-1:0] opd4;
  logic                      alu_mux1_select;
  logic [1:0]                alu_mux2_select;
  logic [2:0]                alu_op_select;
  logic                      is_branch;
  logic                      illegal;

  // Environment side: drives beats in and accepts bundles out
  modport master (
    output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, opd1, opd2, opd3, opd4,
           alu_mux1_select, alu_mux2_select, alu_op_select, is_branch, illegal
  );

  // Stage side
  modport slave (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, opd1, opd2, opd3, opd4,
           alu_mux1_select, alu_mux2_select, alu_op_select, is_branch, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes one instruction per beat into the ALU operand/select
// bundle, registered behind a main + skid pair so in_ready never depends on out_ready.
module alu_issue_stage #(
  parameter int unsigned OPERAND_LENGTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus
);

  localparam int unsigned W = OPERAND_LENGTH;

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Result source select
  localparam logic [1:0] MUX2_ADD   = 2'b00;
  localparam logic [1:0] MUX2_LOGIC = 2'b01;
  localparam logic [1:0] MUX2_SHIFT = 2'b10;
  localparam logic [1:0] MUX2_CMP   = 2'b11;

  // Unit operation codes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b010;
  localparam logic [2:0] OP_GE  = 3'b011;
  localparam logic [2:0] OP_LTU = 3'b100;
  localparam logic [2:0] OP_GEU = 3'b101;

  typedef struct packed {
    logic [W-1:0] opd1;
    logic [W-1:0] opd2;
    logic [W-1:0] opd3;
    logic [W-1:0] opd4;
    logic         mux1;
    logic [1:0]   mux2;
    logic [2:0]   op;
    logic         is_branch;
    logic         illegal;
  } bundle_t;

  // Instruction fields and immediates
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_f7_zero;
  logic        w_f7_alt;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_shamt;
  logic        w_unused_rd;

  assign w_opcode    = bus.instr[6:0];
  assign w_funct3    = bus.instr[14:12];
  assign w_funct7    = bus.instr[31:25];
  assign w_f7_zero   = (w_funct7 == 7'b0000000);
  assign w_f7_alt    = (w_funct7 == 7'b0100000);
  assign w_imm_i     = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign w_imm_b     = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                        bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign w_imm_u     = {bus.instr[31:12], 12'b0};
  assign w_imm_j     = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                        bus.instr[20], bus.instr[30:21], 1'b0};
  assign w_shamt     = {27'b0, bus.instr[24:20]};
  // rd is consumed by writeback, not by this stage
  assign w_unused_rd = &{1'b0, bus.instr[11:7]};

  bundle_t w_dec;
  logic    w_bad;

  // Decode the presented beat into a bundle; any illegal encoding collapses to an all-zero bundle
  always_comb begin
    w_dec = '0;
    w_bad = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_dec.opd1 = bus.rs1_data;
        w_dec.opd2 = bus.rs2_data;
        w_bad      = !(w_f7_zero ||
                       (w_f7_alt && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
        case (w_funct3)
          3'b000: begin w_dec.mux2 = MUX2_ADD;   w_dec.op = w_funct7[5] ? OP_SUB : OP_ADD; end
          3'b001: begin w_dec.mux2 = MUX2_SHIFT; w_dec.op = OP_SLL; end
          3'b010: begin w_dec.mux2 = MUX2_CMP;   w_dec.op = OP_LT;  end
          3'b011: begin w_dec.mux2 = MUX2_CMP;   w_dec.op = OP_LTU; end
          3'b100: begin w_dec.mux2 = MUX2_LOGIC; w_dec.op = OP_XOR; end
          3'b101: begin w_dec.mux2 = MUX2_SHIFT; w_dec.op = w_funct7[5] ? OP_SRA : OP_SRL; end
          3'b110: begin w_dec.mux2 = MUX2_LOGIC; w_dec.op = OP_OR;  end
          3'b111: begin w_dec.mux2 = MUX2_LOGIC; w_dec.op = OP_AND; end
        endcase
      end
      OPC_OP_IMM: begin
        w_dec.opd1 = bus.rs1_data;
        w_dec.opd2 = W'(w_imm_i);
        case (w_funct3)
          3'b000: begin w_dec.mux2 = MUX2_ADD;   w_dec.op = OP_ADD; end
          3'b001: begin
            w_dec.mux2 = MUX2_SHIFT;
            w_dec.op   = OP_SLL;
            w_dec.opd2 = W'(w_shamt);
            w_bad      = !w_f7_zero;
          end
          3'b010: begin w_dec.mux2 = MUX2_CMP;   w_dec.op = OP_LT;  end
          3'b011: begin w_dec.mux2 = MUX2_CMP;   w_dec.op = OP_LTU; end
          3'b100: begin w_dec.mux2 = MUX2_LOGIC; w_dec.op = OP_XOR; end
          3'b101: begin
            w_dec.mux2 = MUX2_SHIFT;
            w_dec.op   = w_funct7[5] ? OP_SRA : OP_SRL;
            w_dec.opd2 = W'(w_shamt);
            w_bad      = !(w_f7_zero || w_f7_alt);
          end
          3'b110: begin w_dec.mux2 = MUX2_LOGIC; w_dec.op = OP_OR;  end
          3'b111: begin w_dec.mux2 = MUX2_LOGIC; w_dec.op = OP_AND; end
        endcase
      end
      OPC_BRANCH: begin
        // Adder forms the target, compare unit resolves the condition on opd3/opd4
        w_dec.opd1      = bus.pc;
        w_dec.opd2      = W'(w_imm_b);
        w_dec.opd3      = bus.rs1_data;
        w_dec.opd4      = bus.rs2_data;
        w_dec.mux1      = 1'b1;
        w_dec.mux2      = MUX2_ADD;
        w_dec.is_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.op = OP_EQ;
          3'b001:  w_dec.op = OP_NE;
          3'b100:  w_dec.op = OP_LT;
          3'b101:  w_dec.op = OP_GE;
          3'b110:  w_dec.op = OP_LTU;
          3'b111:  w_dec.op = OP_GEU;
          default: w_bad    = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_dec.opd2 = W'(w_imm_u);
      end
      OPC_AUIPC: begin
        w_dec.opd1 = bus.pc;
        w_dec.opd2 = W'(w_imm_u);
      end
      OPC_JAL: begin
        w_dec.opd1 = bus.pc;
        w_dec.opd2 = W'(w_imm_j);
      end
      OPC_JALR: begin
        w_dec.opd1 = bus.rs1_data;
        w_dec.opd2 = W'(w_imm_i);
        w_bad      = (w_funct3 != 3'b000);
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  // Pipeline storage
  bundle_t r_main;
  bundle_t r_skid;
  logic    r_main_valid;
  logic    r_skid_valid;
  logic    w_accept;
  logic    w_advance;

  assign w_accept  = bus.in_valid && !r_skid_valid;
  assign w_advance = !r_main_valid || bus.out_ready;

  // Main/skid update: skid is drained first to keep order; flush wins over accept.
  // With in_ready tied to an empty skid, a skid drain never coincides with an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_advance) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main <= w_dec;
        end
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready        = !r_skid_valid;
  assign bus.out_valid       = r_main_valid;
  assign bus.opd1            = r_main.opd1;
  assign bus.opd2            = r_main.opd2;
  assign bus.opd3            = r_main.opd3;
  assign bus.opd4            = r_main.opd4;
  assign bus.alu_mux1_select = r_main.mux1;
  assign bus.alu_mux2_select = r_main.mux2;
  assign bus.alu_op_select   = r_main.op;
  assign bus.is_branch       = r_main.is_branch;
  assign bus.illegal         = r_main.illegal;

endmodule
